// File: rtl/mc_pkg.sv
// mc_pkg: shared state encoding, control-field codes and condition helpers
// for the multicycle ARM-subset controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Unrecognised data-processing commands fall back to ADD.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    logic [1:0] ctl;
    case (cmd)
      CMD_ADD: ctl = ALU_ADD;
      CMD_SUB: ctl = ALU_SUB;
      CMD_AND: ctl = ALU_AND;
      CMD_ORR: ctl = ALU_ORR;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // nzcv is packed as {N, Z, C, V}.
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, met;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: met = z;
      COND_NE: met = ~z;
      COND_CS: met = c;
      COND_CC: met = ~c;
      COND_MI: met = n;
      COND_PL: met = ~n;
      COND_VS: met = v;
      COND_VC: met = ~v;
      COND_HI: met = c & ~z;
      COND_LS: met = ~c | z;
      COND_GE: met = (n == v);
      COND_LT: met = (n != v);
      COND_GT: met = ~z & (n == v);
      COND_LE: met = z | (n != v);
      COND_AL: met = 1'b1;
      COND_NV: met = 1'b0;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// mc_cond_unit: NZCV flag register plus condition evaluation against the
// registered flags; flag writes are qualified by the condition result.
import mc_pkg::*;

module mc_cond_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  output logic       condex,
  output logic [3:0] flags
);

  assign condex = cond_met(cond, flags);

  // flagw[1] guards N/Z, flagw[0] guards C/V.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= FLAGS_RST;
    end else begin
      if (flagw[1] && condex) flags[3:2] <= aluflags[3:2];
      if (flagw[0] && condex) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM and instruction decode for the multicycle
// ARM-subset datapath; condition/flag handling lives in mc_cond_unit.
import mc_pkg::*;

module mc_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_t state, next_state;

  logic       condex;
  logic [3:0] flags;
  logic [1:0] flagw;
  logic       pcwrite_s, irwrite_s, regwrite_s, memwrite_s;
  logic       adrsrc_s, alusrca_s;
  logic [1:0] alusrcb_s, resultsrc_s, aluctrl_s;
  logic       rd_is_pc;

  assign rd_is_pc = (rd == 4'b1111);

  mc_cond_unit #(
    .FLAGS_RST(FLAGS_RST)
  ) u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .aluflags (ALUFlags),
    .flagw    (flagw),
    .condex   (condex),
    .flags    (flags)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // A failed condition never alters the path; only the write enables drop.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   next_state = funct[5] ? EXECI : EXECR;
          OP_MEM:  next_state = MEMADR;
          OP_BR:   next_state = BRANCH;
          OP_NOP:  next_state = FETCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = funct[0] ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      MEMWB:   next_state = FETCH;
      MEMWR:   next_state = FETCH;
      EXECR:   next_state = ALUWB;
      EXECI:   next_state = ALUWB;
      ALUWB:   next_state = FETCH;
      BRANCH:  next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    pcwrite_s   = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    memwrite_s  = 1'b0;
    adrsrc_s    = 1'b0;
    alusrca_s   = 1'b0;
    alusrcb_s   = SRCB_REG;
    resultsrc_s = RES_ALUOUT;
    aluctrl_s   = ALU_ADD;
    flagw       = 2'b00;
    case (state)
      FETCH: begin
        irwrite_s   = 1'b1;
        pcwrite_s   = 1'b1;
        alusrca_s   = 1'b1;
        alusrcb_s   = SRCB_FOUR;
        resultsrc_s = RES_ALU;
      end
      DECODE: begin
        alusrca_s   = 1'b1;
        alusrcb_s   = SRCB_FOUR;
        resultsrc_s = RES_ALU;
      end
      MEMADR: alusrcb_s = SRCB_IMM;
      MEMRD:  adrsrc_s  = 1'b1;
      MEMWB: begin
        resultsrc_s = RES_MEM;
        pcwrite_s   = rd_is_pc & condex;
        regwrite_s  = ~rd_is_pc & condex;
      end
      MEMWR: begin
        adrsrc_s   = 1'b1;
        memwrite_s = condex;
      end
      EXECR, EXECI: begin
        alusrcb_s = (state == EXECI) ? SRCB_IMM : SRCB_REG;
        aluctrl_s = alu_decode(funct[4:1]);
        // C and V only carry meaning for arithmetic commands.
        if (funct[0])
          flagw = {1'b1, (aluctrl_s == ALU_ADD) || (aluctrl_s == ALU_SUB)};
      end
      ALUWB: begin
        resultsrc_s = RES_ALUOUT;
        pcwrite_s   = rd_is_pc & condex;
        regwrite_s  = ~rd_is_pc & condex;
      end
      BRANCH: begin
        alusrcb_s   = SRCB_IMM;
        resultsrc_s = RES_ALU;
        pcwrite_s   = condex;
      end
      default: ;
    endcase
  end

  // Reset holds the state in FETCH, so only the enables need masking.
  assign PCWrite    = reset & pcwrite_s;
  assign IRWrite    = reset & irwrite_s;
  assign RegWrite   = reset & regwrite_s;
  assign MemWrite   = reset & memwrite_s;
  assign AdrSrc     = adrsrc_s;
  assign ALUSrcA    = alusrca_s;
  assign ALUSrcB    = alusrcb_s;
  assign ResultSrc  = resultsrc_s;
  assign ALUControl = aluctrl_s;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign ImmSrc     = op;

endmodule
